// File: rtl/div_detect_pkg.sv
// Shared types and helpers for the divided-clock ratio detector.
//   state_t    : measurement FSM states
//   DEF_*      : default counter width and lock depth
//   pow2_check : nonzero power-of-two test on a zero-extended count
//   pow2_log2  : bit index of a power-of-two count, 0 otherwise
package div_detect_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_LOCK_CNT = 4;

    // Helpers work on a fixed wide operand so any CNT_W up to this fits.
    localparam int POW2_MAX_W = 32;
    localparam int POW2_LOG_W = $clog2(POW2_MAX_W);

    function automatic logic pow2_check(input logic [POW2_MAX_W-1:0] p);
        return (p != '0) && ((p & (p - POW2_MAX_W'(1))) == '0);
    endfunction

    function automatic logic [POW2_LOG_W-1:0] pow2_log2(input logic [POW2_MAX_W-1:0] p);
        logic [POW2_LOG_W-1:0] r;
        r = '0;
        if (pow2_check(p)) begin
            for (int i = 0; i < POW2_MAX_W; i++) begin
                if (p[i]) r = POW2_LOG_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/divide_ratio_detector_if.sv
// Bundle between the signal source / result consumer and the detector.
//   sig_in       : divided-clock signal under measurement
//   period       : last rise-to-rise interval in clk cycles
//   high_time    : last rise-to-fall interval in clk cycles
//   period_valid : one-cycle pulse on each measurement update
//   locked       : LOCK_CNT consecutive equal periods seen
//   is_pow2      : period is a nonzero power of two
//   ratio_log2   : log2 of period when is_pow2, else 0
//   no_signal    : no rising edge for 2^CNT_W-1 cycles
// master = side that drives sig_in and consumes results; slave = detector.
interface divide_ratio_detector_if
    import div_detect_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    localparam int LOG_W = $clog2(CNT_W);

    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             is_pow2;
    logic [LOG_W-1:0] ratio_log2;
    logic             no_signal;

    modport master (
        output sig_in,
        input  period, high_time, period_valid, locked, is_pow2, ratio_log2, no_signal
    );

    modport slave (
        input  sig_in,
        output period, high_time, period_valid, locked, is_pow2, ratio_log2, no_signal
    );

endinterface

// File: rtl/edge_sync.sv
// Optional synchroniser chain plus one-cycle delay for edge detection.
//   clk, reset : clock and asynchronous active-low reset
//   sig_in     : raw input signal
//   sig_s      : sig_in after SYNC_STAGES flops (wire-through when 0)
//   rise, fall : single-cycle edge strobes of sig_s
module edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic sig_q;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sig_s = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign sig_s = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= 1'b0;
        else        sig_q <= sig_s;
    end

    assign rise = sig_s & ~sig_q;
    assign fall = ~sig_s & sig_q;

endmodule

// File: rtl/divide_ratio_detector.sv
// Measures period and high time of a divided clock in clk cycles, reports
// whether the period is a power of two (with its log2), asserts lock after
// LOCK_CNT equal periods and flags loss of signal after 2^CNT_W-1 cycles
// without a rising edge.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : detector side of divide_ratio_detector_if (sig_in in, results out)
module divide_ratio_detector
    import div_detect_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int SYNC_STAGES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    divide_ratio_detector_if.slave bus
);

    localparam int               LOG_W   = $clog2(CNT_W);
    localparam int               RUN_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] r, input logic same);
        if (!same)        return RUN_W'(1);
        if (r == RUN_MAX) return r;
        return r + RUN_W'(1);
    endfunction

    logic sig_s, rise, fall;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (bus.sig_in),
        .sig_s  (sig_s),
        .rise   (rise),
        .fall   (fall)
    );

    // ---- stage p0: free-running interval counters ----
    logic [CNT_W-1:0] cnt_p0, hcnt_p0, hlat_p0;
    logic             fall_seen_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0       <= '0;
            hcnt_p0      <= '0;
            hlat_p0      <= '0;
            fall_seen_p0 <= 1'b0;
        end else begin
            cnt_p0 <= rise ? CNT_W'(1) : sat_inc(cnt_p0);
            if (rise)       hcnt_p0 <= CNT_W'(1);
            else if (sig_s) hcnt_p0 <= sat_inc(hcnt_p0);
            if (rise) begin
                fall_seen_p0 <= 1'b0;
            end else if (fall) begin
                fall_seen_p0 <= 1'b1;
                hlat_p0      <= hcnt_p0;
            end
        end
    end

    // A rise in the same cycle always takes priority over the timeout.
    logic timeout;
    assign timeout = (cnt_p0 == CNT_MAX) && !rise;

    state_t state_q, state_d;
    logic   do_measure, do_arm, do_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise)    state_d = MEASURE;
            MEASURE: if (timeout) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        do_measure = 1'b0;
        do_arm     = 1'b0;
        do_clear   = timeout;
        case (state_q)
            IDLE:    do_arm     = rise;
            MEASURE: do_measure = rise;
            default: ;
        endcase
    end

    // ---- stage p1: registered results ----
    logic [CNT_W-1:0] period_p1, high_p1;
    logic [LOG_W-1:0] log2_p1;
    logic             vld_p1, locked_p1, pow2_p1, nosig_p1;
    logic [RUN_W-1:0] run_q, run_d;

    assign run_d = run_next(run_q, cnt_p0 == period_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_p1 <= '0;
            high_p1   <= '0;
            log2_p1   <= '0;
            vld_p1    <= 1'b0;
            locked_p1 <= 1'b0;
            pow2_p1   <= 1'b0;
            nosig_p1  <= 1'b0;
            run_q     <= '0;
        end else begin
            vld_p1 <= do_measure;
            if (do_measure) begin
                period_p1 <= cnt_p0;
                // Without a fall since the last rise the high phase never ended.
                high_p1   <= fall_seen_p0 ? hlat_p0 : hcnt_p0;
                pow2_p1   <= pow2_check(POW2_MAX_W'(cnt_p0));
                log2_p1   <= LOG_W'(pow2_log2(POW2_MAX_W'(cnt_p0)));
                run_q     <= run_d;
                locked_p1 <= (run_d == RUN_MAX);
            end else if (do_clear) begin
                period_p1 <= '0;
                high_p1   <= '0;
                pow2_p1   <= 1'b0;
                log2_p1   <= '0;
                run_q     <= '0;
                locked_p1 <= 1'b0;
                nosig_p1  <= 1'b1;
            end else if (do_arm) begin
                nosig_p1  <= 1'b0;
            end
        end
    end

    assign bus.period       = period_p1;
    assign bus.high_time    = high_p1;
    assign bus.period_valid = vld_p1;
    assign bus.locked       = locked_p1;
    assign bus.is_pow2      = pow2_p1;
    assign bus.ratio_log2   = log2_p1;
    assign bus.no_signal    = nosig_p1;

endmodule

// File: tb/tb_divide_ratio_detector.sv
module tb_divide_ratio_detector;

    localparam int CNT_W = 8;
    localparam int LOCK  = 4;

    logic clk = 1'b0;
    logic reset;

    divide_ratio_detector_if #(.CNT_W(CNT_W)) bus();

    divide_ratio_detector #(
        .CNT_W       (CNT_W),
        .LOCK_CNT    (LOCK),
        .SYNC_STAGES (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pattern records: high cycles, low cycles, expected period/high/pow2/log2.
    typedef struct {
        int hi;
        int lo;
        int per;
        int ht;
        int pow2;
        int lg;
    } vec_t;

    typedef struct {
        int per;
        int ht;
        int pow2;
        int lg;
        int lk;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    bit sig_prev = 1'b0;
    int cur_idx = 0;
    int blk = 0;
    int prev_p = 0;
    int run = 0;
    int since_rise = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},    int'(bus.period),       0);
        check({tag, "_high"},      int'(bus.high_time),    0);
        check({tag, "_valid"},     int'(bus.period_valid), 0);
        check({tag, "_locked"},    int'(bus.locked),       0);
        check({tag, "_pow2"},      int'(bus.is_pow2),      0);
        check({tag, "_log2"},      int'(bus.ratio_log2),   0);
        check({tag, "_no_signal"}, int'(bus.no_signal),    0);
    endtask

    // One clk cycle of sig_in. A rise while armed completes the period of
    // record cur_idx; its expected result is queued on the sampling edge.
    task automatic tick(input bit v);
        bit   r;
        bit   do_push;
        exp_t e;
        r       = v && !sig_prev;
        do_push = 1'b0;
        e       = '{0, 0, 0, 0, 0};
        if (r) begin
            if (armed) begin
                if (vecs[cur_idx].per == prev_p) run = (run < LOCK) ? run + 1 : LOCK;
                else                             run = 1;
                prev_p  = vecs[cur_idx].per;
                e       = '{vecs[cur_idx].per, vecs[cur_idx].ht, vecs[cur_idx].pow2,
                            vecs[cur_idx].lg, (run == LOCK) ? 1 : 0};
                do_push = 1'b1;
            end
            armed   = 1'b1;
            cur_idx = blk;
        end
        sig_prev   = v;
        bus.sig_in = v;
        @(posedge clk);
        if (do_push) sb.push_back(e);
        #1;
        since_rise = r ? 0 : since_rise + 1;
    endtask

    task automatic run_block(input int idx, input int reps);
        blk = idx;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < vecs[idx].hi; i++) tick(1'b1);
            for (int i = 0; i < vecs[idx].lo; i++) tick(1'b0);
        end
    endtask

    // Scoreboard consumer: a pulse is required exactly when a result is queued.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("period_valid", int'(bus.period_valid), 1);
            check("period",       int'(bus.period),       e.per);
            check("high_time",    int'(bus.high_time),    e.ht);
            check("is_pow2",      int'(bus.is_pow2),      e.pow2);
            check("ratio_log2",   int'(bus.ratio_log2),   e.lg);
            check("locked",       int'(bus.locked),       e.lk);
        end else begin
            check("no_spurious_valid", int'(bus.period_valid), 0);
        end
    end

    initial begin
        vecs[0] = '{1, 1, 2, 1, 1, 1};
        vecs[1] = '{2, 2, 4, 2, 1, 2};
        vecs[2] = '{4, 4, 8, 4, 1, 3};
        vecs[3] = '{2, 4, 6, 2, 0, 0};
        vecs[4] = '{1, 3, 4, 1, 1, 2};

        bus.sig_in = 1'b0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #11;
        check_all_zero("reset");
        #4 reset = 1'b1;

        for (int i = 0; i < 3; i++) tick(1'b0);

        // Steady patterns, including a 4 -> 8 ratio change while locked.
        run_block(0, 6);
        run_block(1, 6);
        run_block(2, 6);
        run_block(3, 5);
        run_block(4, 5);
        run_block(2, 6);
        check("locked_before_timeout", int'(bus.locked), 1);

        // Loss of signal: hold low well past the timeout.
        while (since_rise < 300) begin
            tick(1'b0);
            if (since_rise == 254) check("no_signal_early", int'(bus.no_signal), 0);
            if (since_rise == 255) begin
                check("no_signal_set",    int'(bus.no_signal),  1);
                check("timeout_period",   int'(bus.period),     0);
                check("timeout_high",     int'(bus.high_time),  0);
                check("timeout_locked",   int'(bus.locked),     0);
                check("timeout_pow2",     int'(bus.is_pow2),    0);
                check("timeout_log2",     int'(bus.ratio_log2), 0);
                armed  = 1'b0;
                prev_p = 0;
                run    = 0;
            end
        end
        check("no_signal_held", int'(bus.no_signal), 1);

        // Re-arm: first rise clears no_signal without a measurement.
        blk = 1;
        tick(1'b1);
        check("rearm_no_signal", int'(bus.no_signal), 0);
        check("rearm_period",    int'(bus.period),    0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        run_block(1, 5);
        check("locked_before_reset", int'(bus.locked), 1);

        // Asynchronous reset pulse in the low phase of a locked period.
        #2 reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #2 reset = 1'b1;
        armed    = 1'b0;
        prev_p   = 0;
        run      = 0;
        sig_prev = 1'b0;

        run_block(2, 6);
        blk = 2;
        tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divide_ratio_detector.md
Name: divide_ratio_detector

Overview:
Receiver-side companion to the team's clock divider. It takes a divided-clock signal generated in the same clk domain, measures its period and high time in clk cycles, and reports whether the ratio is a power of two along with its log2. It also flags lock once the ratio is stable and flags loss of signal on timeout. Used as an in-system checker for divider outputs such as divideby2, divideby4 and divideby8.

Parameters:
CNT_W, 8, width of the period and high-time counters; timeout threshold is 2^CNT_W-1 cycles
LOCK_CNT, 4, number of consecutive equal period measurements required to assert locked (minimum 2)
SYNC_STAGES, 0, synchroniser flops on sig_in; 0 means sig_in is already synchronous to clk

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset; clears all state while low
sig_in  input  1  divided-clock signal under measurement
period  output  CNT_W  last measured period in clk cycles, from rise to rise
high_time  output  CNT_W  last measured high time in clk cycles, from rise to fall
period_valid  output  1  one-cycle pulse when period and high_time update
locked  output  1  LOCK_CNT consecutive equal periods seen
is_pow2  output  1  period is a nonzero power of two
ratio_log2  output  $clog2(CNT_W)  bit index of period when is_pow2=1, else 0
no_signal  output  1  no rising edge for 2^CNT_W-1 cycles

Behaviour:
- Reset (reset=0, async): every output is 0; internal counters are 0; state is IDLE; sig_q is 0.
- Front end: sig_s is sig_in after SYNC_STAGES flops. sig_q is sig_s delayed one clk.
- Edge detection: rise = sig_s & ~sig_q; fall = ~sig_s & sig_q.
- Cycle counter cnt:
  - On rise, cnt loads 1.
  - Otherwise cnt increments, saturating at all-ones.
  - hcnt counts the same way but increments only while sig_s=1; it loads 1 on rise.
- State IDLE: wait for rise, then go to MEASURE.
  - No outputs update in IDLE except no_signal, which clears on rise.
- State MEASURE, on each rise:
  - period <= cnt.
  - high_time <= latched hcnt value, captured at the last fall.
  - period_valid pulses for 1 cycle.
  - The run counter updates: new period equal to previous period gives +1, saturating at LOCK_CNT; unequal gives 1.
  - locked <= (new run == LOCK_CNT).
- Output timing: all outputs are registered and update on the clk edge that samples the rise.
  - The first period_valid comes at the second rise after IDLE.
- Timeout: if cnt reaches 2^CNT_W-1 with no rise:
  - no_signal <= 1; locked, period, high_time, is_pow2 and ratio_log2 <= 0.
  - Run counter <= 0; go to IDLE.
  - period_valid does not pulse.
- Missing fall: if no fall occurred between two rises (glitch-free constant high is impossible for a rise-to-rise interval), high_time reports the saturated hcnt value.
- is_pow2 and ratio_log2 are registered alongside period and computed from the new period value.
  - is_pow2 = (p != 0) && ((p & (p-1)) == 0).
- Simultaneous timeout and rise in the same cycle: rise wins, and the measurement is taken normally.
- Ratio change: the first unequal period drops locked on that same update edge; relock follows after LOCK_CNT-1 further matches.
- Reset asserted mid-measurement: immediate clear as above; after release, behaviour is identical to power-up.

Decomposition:
- Package div_detect_pkg:
  - state enum {IDLE, MEASURE};
  - function to compute is_pow2/log2 of a CNT_W value;
  - default constants for CNT_W and LOCK_CNT.
- Sub-module edge_sync: SYNC_STAGES flop chain plus the sig_q delay. It outputs sig_s, rise and fall, and is reusable for other divider checks.
- The counter, FSM and lock logic stay in the top module.

Test Plan:
- sig_in driven by a divide-by-2 toggle after reset release -> first period_valid gives period=2, high_time=1, is_pow2=1, ratio_log2=1; locked=1 on the 4th measurement.
- Divide-by-8 pattern (4 high, 4 low) -> period=8, high_time=4, ratio_log2=3, locked after 4 equal periods.
- Ratio switched from 4 to 8 while locked -> locked=0 on the first period=8 update; locked=1 again 3 measurements later.
- Pattern of 2 high, 4 low -> period=6, high_time=2, is_pow2=0, ratio_log2=0.
- sig_in held low for 300 cycles after lock -> no_signal=1 exactly 255 cycles after the last rise; period=0, locked=0; the next rise clears no_signal with no period_valid pulse.
- reset pulsed low for 1 cycle mid-period while locked -> all outputs 0 immediately (asynchronous); the first period_valid comes at the 2nd rise after release.
